// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO peripheral bus: sequencer states,
// peripheral index map and default bus geometry.
package io_bus_pkg;

    localparam int IO_NUM_PERIPH = 4;
    localparam int IO_DATA_W     = 32;
    localparam int IO_ADDR_W_DEF = 8;

    // Peripheral k is selected by IO word-address bit k.
    localparam int IO_GPIO_BIT  = 0;
    localparam int IO_UART_BIT  = 1;
    localparam int IO_TIMER_BIT = 2;
    localparam int IO_SPI_BIT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// Master-side request/response signals and peripheral-side strobes of
// the two-master IO bus. The arbiter uses the slave view; whoever drives
// the masters and models the peripherals uses the master view.
interface io_bus_arbiter_if
    import io_bus_pkg::*;
#(
    parameter int NUM_PERIPH = IO_NUM_PERIPH,
    parameter int IO_ADDR_W  = IO_ADDR_W_DEF,
    parameter int DATA_W     = IO_DATA_W
);

    logic                         m0_req;
    logic                         m0_we;
    logic [IO_ADDR_W-1:0]         m0_addr;
    logic [DATA_W-1:0]            m0_wdata;
    logic                         m0_ack;
    logic [DATA_W-1:0]            m0_rdata;
    logic                         m0_err;

    logic                         m1_req;
    logic                         m1_we;
    logic [IO_ADDR_W-1:0]         m1_addr;
    logic [DATA_W-1:0]            m1_wdata;
    logic                         m1_ack;
    logic [DATA_W-1:0]            m1_rdata;
    logic                         m1_err;

    logic [NUM_PERIPH-1:0]        p_sel;
    logic                         p_write_en;
    logic                         p_read_en;
    logic [DATA_W-1:0]            p_wdata;
    logic [NUM_PERIPH*DATA_W-1:0] p_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata, m0_err,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata, m1_err,
        output p_sel, p_write_en, p_read_en, p_wdata,
        input  p_rdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata, m0_err,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata, m1_err,
        input  p_sel, p_write_en, p_read_en, p_wdata,
        output p_rdata
    );

endinterface

// File: rtl/io_addr_decoder.sv
// One-hot IO word-address decoder. The low NUM_PERIPH address bits must be
// exactly one-hot; upper bits are ignored. Zero or multi-hot yields no select.
module io_addr_decoder
    import io_bus_pkg::*;
#(
    parameter int NUM_PERIPH = IO_NUM_PERIPH,
    parameter int IO_ADDR_W  = IO_ADDR_W_DEF
) (
    input  logic [IO_ADDR_W-1:0]  addr,
    output logic [NUM_PERIPH-1:0] sel,
    output logic                  onehot_ok
);

    logic [NUM_PERIPH-1:0] low;
    logic [NUM_PERIPH-1:0] low_m1;

    assign low       = addr[NUM_PERIPH-1:0];
    assign low_m1    = low - NUM_PERIPH'(1);
    // Clearing the lowest set bit leaves zero only for a single-bit value.
    assign onehot_ok = (low != '0) && ((low & low_m1) == '0);
    assign sel       = onehot_ok ? low : '0;

    generate
        if (IO_ADDR_W > NUM_PERIPH) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^addr[IO_ADDR_W-1:NUM_PERIPH];
        end
    endgenerate

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master round-robin arbiter and sequencer for the IO peripheral bus.
// Each transaction takes IDLE -> ACCESS -> RESP; every output is registered.
//
// Handshake: a master raises req with we/addr/wdata and holds them stable
// until it sees ack (a one-cycle pulse, with rdata/err valid alongside).
// req is sampled only in IDLE, so in the cycle after ack the master either
// drops req or presents the next payload; req still high there is a new
// transaction.
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter int NUM_PERIPH = IO_NUM_PERIPH,
    parameter int IO_ADDR_W  = IO_ADDR_W_DEF,
    parameter int DATA_W     = IO_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    io_bus_arbiter_if.slave   bus,
    output state_e            dbg_state
);

    state_e                state_q, state_d;
    logic                  ptr_q, ptr_d;     // 1 = prefer m1 on contention
    logic                  gnt_q, gnt_d;     // granted master id
    logic                  we_q, we_d;
    logic                  bad_q, bad_d;     // latched decode error

    logic                  pick;
    logic                  pick_we;
    logic [IO_ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]     pick_wdata;
    logic [NUM_PERIPH-1:0] dec_sel;
    logic                  dec_ok;
    logic [DATA_W-1:0]     rd_slice;
    logic [DATA_W-1:0]     rd_data;

    logic [NUM_PERIPH-1:0] sel_q, sel_d;
    logic                  wen_q, wen_d;
    logic                  ren_q, ren_d;
    logic [DATA_W-1:0]     pwd_q, pwd_d;
    logic                  ack0_q, ack0_d, ack1_q, ack1_d;
    logic                  err0_q, err0_d, err1_q, err1_d;
    logic [DATA_W-1:0]     rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    // Choose the candidate master: the lone requester, or the preferred one.
    always_comb begin
        pick       = (bus.m0_req && bus.m1_req) ? ptr_q : bus.m1_req;
        pick_we    = pick ? bus.m1_we    : bus.m0_we;
        pick_addr  = pick ? bus.m1_addr  : bus.m0_addr;
        pick_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
    end

    io_addr_decoder #(
        .NUM_PERIPH (NUM_PERIPH),
        .IO_ADDR_W  (IO_ADDR_W)
    ) u_dec (
        .addr      (pick_addr),
        .sel       (dec_sel),
        .onehot_ok (dec_ok)
    );

    // Read data of the selected peripheral; writes and decode errors give 0.
    always_comb begin
        rd_slice = '0;
        for (int k = 0; k < NUM_PERIPH; k++) begin
            if (sel_q[k]) rd_slice = rd_slice | bus.p_rdata[k*DATA_W +: DATA_W];
        end
        rd_data = we_q ? '0 : rd_slice;
    end

    // Next state, grant latching and next values of all registered outputs.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        we_d     = we_q;
        bad_d    = bad_q;
        sel_d    = '0;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        pwd_d    = '0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = '0;
        rdata1_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.m0_req || bus.m1_req) begin
                    gnt_d   = pick;
                    we_d    = pick_we;
                    bad_d   = ~dec_ok;
                    sel_d   = dec_sel;
                    wen_d   = dec_ok & pick_we;
                    ren_d   = dec_ok & ~pick_we;
                    pwd_d   = pick_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (gnt_q) begin
                    ack1_d   = 1'b1;
                    rdata1_d = rd_data;
                    err1_d   = bad_q;
                end else begin
                    ack0_d   = 1'b1;
                    rdata0_d = rd_data;
                    err0_d   = bad_q;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                ptr_d   = ~gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and round-robin pointer register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Transaction context and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_q    <= 1'b0;
            we_q     <= 1'b0;
            bad_q    <= 1'b0;
            sel_q    <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            pwd_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            we_q     <= we_d;
            bad_q    <= bad_d;
            sel_q    <= sel_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            pwd_q    <= pwd_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign bus.p_sel      = sel_q;
    assign bus.p_write_en = wen_q;
    assign bus.p_read_en  = ren_q;
    assign bus.p_wdata    = pwd_q;
    assign bus.m0_ack     = ack0_q;
    assign bus.m0_rdata   = rdata0_q;
    assign bus.m0_err     = err0_q;
    assign bus.m1_ack     = ack1_q;
    assign bus.m1_rdata   = rdata1_q;
    assign bus.m1_err     = err1_q;
    assign dbg_state      = state_q;

endmodule
